// File: rtl/prefix_addsub_pipe.sv
// prefix_addsub_pipe
// Two-stage pipelined adder/subtractor built on a Brent-Kung prefix carry
// network. Computes A+B+cin (sub_i=0) or A-B-bin (sub_i=1), with carry/borrow,
// signed overflow, zero and negative flags. Valid/ready flow control on both
// sides; throughput of one beat per cycle and a latency of 2 cycles.
//
// Optional feature macro: DROMOS_ADDSUB_SAT_EN
//   When defined, adds sat_i. A beat with sat_i=1 that overflows clamps its
//   result to the most positive or most negative value.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   in_valid_i   operand beat valid
//   in_ready_o   block can accept a beat this cycle
//   a_i, b_i     operands (WIDTH bits)
//   sub_i        0 = add, 1 = subtract
//   cin_i        carry-in (add) / borrow-in (subtract)
//   sat_i        saturate on overflow (only with DROMOS_ADDSUB_SAT_EN)
//   out_valid_o  result beat valid
//   out_ready_i  consumer accepts the result this cycle
//   sum_o        result (WIDTH bits)
//   cout_o       carry-out (add) / borrow-out (subtract)
//   ovf_o        two's-complement signed overflow
//   zero_o       sum_o == 0
//   neg_o        sum_o[WIDTH-1]
module prefix_addsub_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sub_i,
  input  logic             cin_i,
`ifdef DROMOS_ADDSUB_SAT_EN
  input  logic             sat_i,
`endif
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o,
  output logic             zero_o,
  output logic             neg_o
);

  localparam int LOG_W = $clog2(WIDTH);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s1_c0;
  logic             s1_sub;
`ifdef DROMOS_ADDSUB_SAT_EN
  logic             s1_sat;
`endif

  logic             s2_valid;
  logic             s2_ready;

  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] gg;
  logic [WIDTH-1:0] pp;
  logic [WIDTH-1:0] sum_raw;
  logic [WIDTH-1:0] sum_fin;
  logic             raw_carry;
  logic             ovf;

  assign s2_ready    = !s2_valid || out_ready_i;
  assign in_ready_o  = !s1_valid || s2_ready;
  assign out_valid_o = s2_valid;

  // Prefix network. gg/pp are updated in place: within one level the bits
  // being written are never the source of another combine at that level.
  // Out-of-range source indices are clamped to 0 so the unrolled dead
  // branches never select outside the vector.
  always_comb begin
    int s;
    int j;
    p  = s1_a ^ s1_b;
    gg = s1_a & s1_b;
    gg[0] = gg[0] | (p[0] & s1_c0);  // fold carry-in into bit 0
    pp = p;
    // up-sweep
    for (int l = 0; l < LOG_W; l++) begin
      s = 1 << l;
      for (int i = 0; i < WIDTH; i++) begin
        j = (i >= s) ? (i - s) : 0;
        if ((i >= s) && (((i + 1) % (2 * s)) == 0)) begin
          gg[i] = gg[i] | (pp[i] & gg[j]);
          pp[i] = pp[i] & pp[j];
        end
      end
    end
    // down-sweep fills the remaining prefixes
    for (int l = LOG_W - 2; l >= 0; l--) begin
      s = 1 << l;
      for (int i = 0; i < WIDTH; i++) begin
        j = (i >= s) ? (i - s) : 0;
        if ((i >= 2 * s) && (((i + 1) % (2 * s)) == s)) begin
          gg[i] = gg[i] | (pp[i] & gg[j]);
          pp[i] = pp[i] & pp[j];
        end
      end
    end
  end

  // gg[i] is now the carry out of bit i (c[i]).
  assign sum_raw   = p ^ {gg[WIDTH-2:0], s1_c0};
  assign raw_carry = gg[WIDTH-1];
  assign ovf       = gg[WIDTH-1] ^ gg[WIDTH-2];

  always_comb begin
    sum_fin = sum_raw;
`ifdef DROMOS_ADDSUB_SAT_EN
    // On overflow the true result has the sign of A.
    if (s1_sat && ovf) begin
      sum_fin = s1_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                              : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_c0    <= 1'b0;
      s1_sub   <= 1'b0;
`ifdef DROMOS_ADDSUB_SAT_EN
      s1_sat   <= 1'b0;
`endif
    end else begin
      if (in_ready_o) begin
        s1_valid <= in_valid_i;
      end
      if (in_valid_i && in_ready_o) begin
        // subtract as A + ~B + ~bin
        s1_a   <= a_i;
        s1_b   <= sub_i ? ~b_i : b_i;
        s1_c0  <= sub_i ? ~cin_i : cin_i;
        s1_sub <= sub_i;
`ifdef DROMOS_ADDSUB_SAT_EN
        s1_sat <= sat_i;
`endif
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s2_valid <= 1'b0;
      sum_o    <= '0;
      cout_o   <= 1'b0;
      ovf_o    <= 1'b0;
      zero_o   <= 1'b0;
      neg_o    <= 1'b0;
    end else begin
      if (s2_ready) begin
        s2_valid <= s1_valid;
      end
      if (s1_valid && s2_ready) begin
        sum_o  <= sum_fin;
        cout_o <= s1_sub ? ~raw_carry : raw_carry;
        ovf_o  <= ovf;
        zero_o <= (sum_fin == '0);
        neg_o  <= sum_fin[WIDTH-1];
      end
    end
  end

endmodule

// File: doc/prefix_addsub_pipe.md
Name: prefix_addsub_pipe

Overview:
- Two-stage pipelined adder/subtractor built on the team's Brent-Kung prefix carry network (black/gray cells).
- Sits in the datapath between an operand source and a result consumer, with valid/ready flow control on both sides.
- Computes A+B+cin or A-B-bin.
- Produces sum and carry/borrow, signed overflow, zero and negative flags.

Parameters:
- WIDTH, 8, operand/result width in bits; power of two, 4..64.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- in_valid_i  input  1  operand beat valid.
- in_ready_o  output  1  block can accept a beat this cycle.
- a_i  input  WIDTH  operand A.
- b_i  input  WIDTH  operand B.
- sub_i  input  1  0 = add, 1 = subtract.
- cin_i  input  1  carry-in (add) or borrow-in (subtract).
- out_valid_o  output  1  result beat valid.
- out_ready_i  input  1  consumer accepts the result this cycle.
- sum_o  output  WIDTH  result.
- cout_o  output  1  add: carry-out. Subtract: borrow-out, 1 when A < B+bin unsigned.
- ovf_o  output  1  two's-complement signed overflow.
- zero_o  output  1  sum_o == 0.
- neg_o  output  1  sum_o[WIDTH-1].

Behaviour:
- One clock domain. Reset is asynchronous and active-low.
- Reset values:
  - All stage valid bits = 0, so out_valid_o = 0.
  - Data registers and flags = 0.
  - in_ready_o = 1 immediately after reset.
- Handshake:
  - A beat transfers on the input when in_valid_i & in_ready_o.
  - A beat transfers on the output when out_valid_o & out_ready_i.
  - No combinational path from in_valid_i to out_valid_o.
- Stage 1 (operand register), captured on an input transfer:
  - Captures A.
  - Captures B' = sub ? ~B : B.
  - Captures c0 = sub ? ~cin : cin, so subtract = A + ~B + 1 - bin.
  - Captures the sub flag.
- Stage 2 (result register):
  - Combinationally forms per-bit p = A^B' and g = A&B'.
  - Folds c0 into bit 0 as g0' = g0 | (p0 & c0).
  - Runs the Brent-Kung prefix tree over WIDTH bits, then sum[i] = p[i] ^ c[i-1], with c[-1] = c0.
  - Registers the result and flags.
- Flag rules:
  - Raw carry = group generate of bits WIDTH-1..0.
  - cout_o = raw carry for add, ~raw carry for subtract.
  - ovf_o = c[WIDTH-1] ^ c[WIDTH-2].
- Latency: exactly 2 cycles from input transfer to out_valid_o when no backpressure.
- Throughput: 1 beat/cycle.
- Ready chain:
  - s2_ready = !s2_valid | out_ready_i.
  - in_ready_o = !s1_valid | s2_ready.
  - Each stage loads when its upstream is valid and it is ready.
  - A stage whose beat leaves and receives no new beat clears its valid bit.
- Backpressure:
  - Holding out_ready_i = 0 keeps sum_o and the flags stable while out_valid_o = 1.
  - With the pipe full and out_ready_i = 0, in_ready_o = 0 after at most 2 accepted beats.
  - Beats are never dropped or duplicated; order is preserved.
- Simultaneous events: a full pipe with out_ready_i = 1 and in_valid_i = 1 accepts, advances and emits in the same cycle.
- Boundary cases:
  - Wrap-around: add 0xFF+0x01 gives sum 0x00, cout 1, zero 1 (WIDTH=8).
  - Subtract 0x00-0x01 gives sum 0xFF, borrow 1, neg 1.
- Reset mid-operation: asynchronously clears both valid bits. In-flight beats are discarded and no output beat appears after release.
- in_valid_i may drop without a transfer; operand inputs are don't-care when in_valid_i = 0.

Optional Feature:
- Macro: DROMOS_ADDSUB_SAT_EN.
- Defined: adds input sat_i (1 bit), captured in stage 1 with the operands.
  - When sat_i = 1 and ovf = 1: sum_o clamps to 0x7F..F if the true result is positive (operand A sign = 0), else 0x80..0.
  - When sat_i = 1 and ovf = 1: ovf_o still reports 1; zero_o and neg_o reflect the clamped value.
  - Latency unchanged.
- Undefined: port sat_i is absent. Results always wrap modulo 2^WIDTH.

Test Plan:
- Reset then single add A=0x12, B=0x34, cin=0, sub=0 -> out_valid_o exactly 2 cycles later; sum 0x46, cout 0, ovf 0, zero 0, neg 0.
- Subtract A=0x00, B=0x01, bin=0 -> sum 0xFF, cout(borrow) 1, neg 1, ovf 0. Add A=0xFF, B=0x01 -> sum 0x00, cout 1, zero 1.
- Signed overflow: add 0x7F+0x01 -> sum 0x80, ovf 1, neg 1. Subtract 0x80-0x01 -> sum 0x7F, ovf 1. With DROMOS_ADDSUB_SAT_EN and sat_i=1 -> 0x7F and 0x80 respectively.
- Backpressure: stream 5 beats with out_ready_i=0 -> in_ready_o=0 after 2 accepted. Release out_ready_i -> all 5 results emerge in order, unchanged while stalled.
- Back-to-back full throughput: 16 random beats with in_valid_i=1 and out_ready_i=1 -> one result per cycle, first at cycle 2, all matching a reference model.
- Reset asserted with 2 beats in flight -> out_valid_o=0 immediately. After release, no stale beat is emitted and in_ready_o=1.
